branch_target_lut: RTL and testbench

Programmable, parametrised branch-target lookup table for the basic processor fetch stage. A narrow branch index selects a wide PC target from a writable table. Each entry is either absolute or PC-relative. Lookups are registered, with one-cycle latency. A clear sequencer invalidates the table one entry per cycle.

---
 rtl/branch_target_lut.sv | 186 ++++++++++++++++++
 tb/tb_branch_target_lut.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_lut.sv
// Branch-target lookup table: writable absolute/PC-relative entries, registered lookup, clear sweep.
// Optional macro LUT_BYPASS_EN forwards a same-cycle write to a lookup of the same index.
module branch_target_lut #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              lookup_en,
    input  logic [IDX_W-1:0]  lookup_idx,
    input  logic [ADDR_W-1:0] pc,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic              wr_rel,
    input  logic              clear,
    output logic [ADDR_W-1:0] target,
    output logic              target_valid,
    output logic              miss,
    output logic              busy
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   sweep_cnt_r;
    logic               busy_r;
    logic [DEPTH-1:0]   valid_r;
    logic [ADDR_W-1:0]  data_r [DEPTH];
    logic               rel_r  [DEPTH];

    logic [ADDR_W-1:0]  target_r;
    logic               target_valid_r;
    logic               miss_r;

    logic               wr_accept_s;
    logic               entry_valid_s;
    logic [ADDR_W-1:0]  entry_data_s;
    logic               entry_rel_s;
    logic [ADDR_W-1:0]  next_target_s;
    logic               next_miss_s;

    // Relative targets wrap modulo 2**ADDR_W; negative offsets fall out of two's complement.
    function automatic logic [ADDR_W-1:0] rel_target(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] offset
    );
        return base + offset;
    endfunction

    // Writes are only honoured while idle; during a sweep they are dropped.
    always_comb begin
        wr_accept_s = wr_en && (state_r == ST_IDLE);
    end

    // Clear sequencer: one entry per cycle, leaves after the last index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            sweep_cnt_r <= {IDX_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        state_r     <= ST_CLEAR;
                        sweep_cnt_r <= {IDX_W{1'b0}};
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        sweep_cnt_r <= sweep_cnt_r;
                        busy_r      <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    sweep_cnt_r <= sweep_cnt_r + IDX_W'(1);
                    if (sweep_cnt_r == IDX_W'(DEPTH - 1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sweep_cnt_r <= {IDX_W{1'b0}};
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: the only reset part of the table storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            valid_r[sweep_cnt_r] <= 1'b0;
        end else if (wr_accept_s) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Entry payload behaves like plain memory and is never reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            data_r[wr_idx] <= wr_data;
            rel_r[wr_idx]  <= wr_rel;
        end
    end

    // Select the entry seen by this cycle's lookup.
    always_comb begin
        entry_valid_s = valid_r[lookup_idx];
        entry_data_s  = data_r[lookup_idx];
        entry_rel_s   = rel_r[lookup_idx];
`ifdef LUT_BYPASS_EN
        if (wr_accept_s && (wr_idx == lookup_idx)) begin
            entry_valid_s = 1'b1;
            entry_data_s  = wr_data;
            entry_rel_s   = wr_rel;
        end else begin
            entry_valid_s = valid_r[lookup_idx];
            entry_data_s  = data_r[lookup_idx];
            entry_rel_s   = rel_r[lookup_idx];
        end
`else
        if (state_r == ST_CLEAR) begin
            entry_valid_s = 1'b0;
        end else begin
            entry_valid_s = valid_r[lookup_idx];
        end
`endif
    end

    // Resolve the lookup result; a sweep forces a miss regardless of entry state.
    always_comb begin
        next_target_s = {ADDR_W{1'b0}};
        next_miss_s   = 1'b1;
        if (state_r == ST_CLEAR) begin
            next_target_s = {ADDR_W{1'b0}};
            next_miss_s   = 1'b1;
        end else if (!entry_valid_s) begin
            next_target_s = {ADDR_W{1'b0}};
            next_miss_s   = 1'b1;
        end else if (entry_rel_s) begin
            next_target_s = rel_target(pc, entry_data_s);
            next_miss_s   = 1'b0;
        end else begin
            next_target_s = entry_data_s;
            next_miss_s   = 1'b0;
        end
    end

    // Output registers: target/miss hold when no lookup is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_r       <= {ADDR_W{1'b0}};
            target_valid_r <= 1'b0;
            miss_r         <= 1'b0;
        end else begin
            target_valid_r <= lookup_en;
            if (lookup_en) begin
                target_r <= next_target_s;
                miss_r   <= next_miss_s;
            end else begin
                target_r <= target_r;
                miss_r   <= miss_r;
            end
        end
    end

    assign target       = target_r;
    assign target_valid = target_valid_r;
    assign miss         = miss_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_branch_target_lut.sv
// Directed self-checking bench for branch_target_lut (ADDR_W=16, IDX_W=5).
module tb_branch_target_lut;

    logic        clk;
    logic        reset_n;
    logic        lookup_en;
    logic [4:0]  lookup_idx;
    logic [15:0] pc;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [15:0] wr_data;
    logic        wr_rel;
    logic        clear;
    logic [15:0] target;
    logic        target_valid;
    logic        miss;
    logic        busy;

    int errors = 0;
    int checks = 0;

    branch_target_lut #(.ADDR_W(16), .IDX_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_en    (lookup_en),
        .lookup_idx   (lookup_idx),
        .pc           (pc),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_rel       (wr_rel),
        .clear        (clear),
        .target       (target),
        .target_valid (target_valid),
        .miss         (miss),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_en = 1'b0; lookup_idx = 5'd0; pc = 16'h0000;
        wr_en = 1'b0; wr_idx = 5'd0; wr_data = 16'h0000; wr_rel = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [15:0] d, input logic rel);
        wr_en = 1'b1; wr_idx = idx; wr_data = d; wr_rel = rel;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_lookup(input logic [4:0] idx, input logic [15:0] p);
        lookup_en = 1'b1; lookup_idx = idx; pc = p;
        step();
        lookup_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step(); step();
        checks++;
        if (target !== 16'h0000 || target_valid !== 1'b0 || miss !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got target=%h tv=%b miss=%b busy=%b, want 0000 0 0 0",
                     target, target_valid, miss, busy);
        end
        reset_n = 1'b1;
        step();
        do_lookup(5'd3, 16'h0000);
        checks++;
        if (target_valid !== 1'b1 || miss !== 1'b1 || target !== 16'h0000) begin
            errors++;
            $display("FAIL reset_lookup3: got tv=%b miss=%b target=%h, want 1 1 0000",
                     target_valid, miss, target);
        end
    endtask

    task automatic test_absolute();
        do_write(5'd2, 16'h0F03, 1'b0);
        do_lookup(5'd2, 16'h5555);
        checks++;
        if (target_valid !== 1'b1 || miss !== 1'b0 || target !== 16'h0F03) begin
            errors++;
            $display("FAIL abs_lookup: got tv=%b miss=%b target=%h, want 1 0 0f03",
                     target_valid, miss, target);
        end
        step();
        checks++;
        if (target_valid !== 1'b0 || target !== 16'h0F03 || miss !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got tv=%b target=%h miss=%b, want 0 0f03 0",
                     target_valid, target, miss);
        end
    endtask

    task automatic test_relative();
        do_write(5'd0, 16'hFFFF, 1'b1);
        do_lookup(5'd0, 16'h0010);
        checks++;
        if (target !== 16'h000F || miss !== 1'b0 || target_valid !== 1'b1) begin
            errors++;
            $display("FAIL rel_neg: got target=%h miss=%b, want 000f 0", target, miss);
        end
        do_lookup(5'd0, 16'h0000);
        checks++;
        if (target !== 16'hFFFF || miss !== 1'b0) begin
            errors++;
            $display("FAIL rel_wrap_low: got target=%h miss=%b, want ffff 0", target, miss);
        end
        do_write(5'd7, 16'h0100, 1'b1);
        do_lookup(5'd7, 16'hFF80);
        checks++;
        if (target !== 16'h0080 || miss !== 1'b0) begin
            errors++;
            $display("FAIL rel_wrap_high: got target=%h miss=%b, want 0080 0", target, miss);
        end
    endtask

    task automatic test_same_cycle();
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 16'h1234; wr_rel = 1'b0;
        lookup_en = 1'b1; lookup_idx = 5'd5; pc = 16'h0000;
        step();
        wr_en = 1'b0; lookup_en = 1'b0;
        checks++;
`ifdef LUT_BYPASS_EN
        if (target !== 16'h1234 || miss !== 1'b0 || target_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_bypass: got target=%h miss=%b, want 1234 0", target, miss);
        end
`else
        if (target !== 16'h0000 || miss !== 1'b1 || target_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_old: got target=%h miss=%b, want 0000 1", target, miss);
        end
`endif
        do_lookup(5'd5, 16'h0000);
        checks++;
        if (target !== 16'h1234 || miss !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_after: got target=%h miss=%b, want 1234 0", target, miss);
        end
    endtask

    task automatic test_clear_sweep();
        int busy_cycles;
        int miss_errs;
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), 16'h1000 + 16'(i), 1'b0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        busy_cycles = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy_rise: got busy=%b, want 1", busy);
        end
        if (busy === 1'b1) busy_cycles++;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                wr_en = 1'b1; wr_idx = 5'd4; wr_data = 16'hABCD; wr_rel = 1'b0;
                lookup_en = 1'b1; lookup_idx = 5'd31;
                clear = 1'b1;
            end
            step();
            wr_en = 1'b0; lookup_en = 1'b0; clear = 1'b0;
            if (k == 10) begin
                checks++;
                if (miss !== 1'b1 || target !== 16'h0000 || target_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_sweep_lookup31: got miss=%b target=%h, want 1 0000",
                             miss, target);
                end
            end
            if (busy === 1'b1) busy_cycles++;
            else break;
        end
        checks++;
        if (busy_cycles != 32) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d busy cycles, want 32", busy_cycles);
        end
        miss_errs = 0;
        for (int i = 0; i < 32; i++) begin
            do_lookup(5'(i), 16'h0000);
            if (miss !== 1'b1 || target !== 16'h0000) miss_errs++;
        end
        checks++;
        if (miss_errs != 0) begin
            errors++;
            $display("FAIL post_sweep_all_miss: got %0d indices not missing, want 0", miss_errs);
        end
        do_lookup(5'd4, 16'h0000);
        checks++;
        if (miss !== 1'b1) begin
            errors++;
            $display("FAIL dropped_write_idx4: got miss=%b target=%h, want 1 0000", miss, target);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cycles;
        do_write(5'd20, 16'h2020, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 9; k++) step();
        lookup_en = 1'b1; lookup_idx = 5'd1;
        step();
        lookup_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || target_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: got busy=%b tv=%b, want 0 0", busy, target_valid);
        end
        step(); step(); step();
        reset_n = 1'b1;
        do_lookup(5'd20, 16'h0000);
        checks++;
        if (miss !== 1'b1 || target !== 16'h0000) begin
            errors++;
            $display("FAIL reset_invalidates_20: got miss=%b target=%h, want 1 0000", miss, target);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
            else break;
        end
        checks++;
        if (busy_cycles != 32) begin
            errors++;
            $display("FAIL clear_after_reset_len: got %0d busy cycles, want 32", busy_cycles);
        end
    endtask

    task automatic test_write_with_clear();
        wr_en = 1'b1; wr_idx = 5'd9; wr_data = 16'h0909; wr_rel = 1'b0;
        clear = 1'b1;
        step();
        wr_en = 1'b0; clear = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_clear_busy: got busy=%b, want 1", busy);
        end
        for (int k = 0; k < 40 && busy === 1'b1; k++) step();
        do_lookup(5'd9, 16'h0000);
        checks++;
        if (miss !== 1'b1) begin
            errors++;
            $display("FAIL wr_clear_swept: got miss=%b target=%h, want 1 0000", miss, target);
        end
    endtask

    initial begin
        test_reset();
        test_absolute();
        test_relative();
        test_same_cycle();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_write_with_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
